regfile_wb_arbiter: RTL and testbench
=====================================

# regfile_wb_arbiter

Write-back arbiter and pending-write scoreboard for the 32x32 MIPS register file. Two producers, the ALU result path and the load/memory path, compete for the register file's single write port. This block grants one write per cycle and drives the write port from registered outputs. It also tracks which destination registers have an issued but not yet written result, so decode can detect RAW hazards.

## Interface
Parameters:
- NREG, 32, number of architectural registers; address width is log2(NREG) = 5
- DW, 32, data width

Ports:
- clk  in  1  system clock, rising-edge
- rst  in  1  asynchronous, active-high reset
- alu_valid  in  1  ALU write-back request
- alu_ready  out  1  ALU request accepted this cycle when alu_valid & alu_ready
- alu_waddr  in  5  ALU destination register
- alu_wdata  in  32  ALU result
- mem_valid  in  1  load write-back request
- mem_ready  out  1  load request accepted when mem_valid & mem_ready
- mem_waddr  in  5  load destination register
- mem_wdata  in  32  load data
- issue_valid  in  1  decode issued an instruction with a destination register
- issue_waddr  in  5  destination of the issued instruction
- rf_wren  out  1  register file write enable (registered)
- rf_waddr  out  5  register file write address (registered)
- rf_wdata  out  32  register file write data (registered)
- busy  out  32  scoreboard; bit n = 1 means register n has a pending write

## Operation
- Pointer last_grant (1 bit: ALU/MEM) records the most recent winner of a *contended* cycle.
- Ready rules (combinational, depend only on the other requester):
  - alu_ready = ~mem_valid | (last_grant == MEM)
  - mem_ready = ~alu_valid | (last_grant == ALU)
  - Exactly one handshake when both requesters are valid.
- Round-robin: on a contended cycle the winner is recorded in last_grant. An uncontended handshake does not update last_grant.
- Accepted request: rf_waddr/rf_wdata load the winner's address and data at the next edge. rf_wren = 1 if waddr != 0, else 0 (writes to $zero are accepted and dropped).
- No handshake: rf_wren = 0 at the next edge; rf_waddr/rf_wdata hold their values.
- Scoreboard, per edge:
  - Accepted write to n: clear busy[n].
  - issue_valid to n: set busy[n].
  - Same n, same cycle: set wins, because the issue is a newer producer.
  - n = 0: never set; busy[0] is constant 0.
- Writes to a register whose busy bit is 0 are still performed. The scoreboard is advisory only.

## Timing
- Reset (async assert, sync release): rf_wren=0, rf_waddr=0, rf_wdata=0, busy=0, last_grant=MEM, so ALU wins the first contention.
- Handshake at edge k → rf_wren/rf_waddr/rf_wdata valid in cycle k+1, for exactly one cycle per accepted request. Latency 1.
- Busy clear is visible in cycle k+1, the same cycle rf_wren is high. The register file commits at edge k+1.
- Throughput: one write per cycle; back-to-back accepted requests give continuous rf_wren.
- Requester holding valid without ready must keep waddr/wdata stable. Under sustained contention, grants alternate ALU, MEM, ALU, …
- rst asserted mid-stream discards the registered write: rf_wren falls to 0 immediately (asynchronously), and all busy bits clear.

## Configuration
- REGFILE_WB_FIXED_PRIO_EN
  - Defined: fixed priority, MEM over ALU. alu_ready = ~mem_valid, mem_ready = 1. last_grant is removed.
  - Undefined (default): round-robin as above.

## Test plan
- Reset, then alu_valid with waddr=5, wdata=0x1234 → alu_ready=1; next cycle rf_wren=1, rf_waddr=5, rf_wdata=0x00001234; following cycle rf_wren=0.
- Both valid for 4 cycles (alu waddr=3, mem waddr=4) → grant order ALU, MEM, ALU, MEM; rf_waddr sequence 3,4,3,4 with rf_wren high throughout. Under REGFILE_WB_FIXED_PRIO_EN → 4,4,4,4 and alu_ready=0.
- mem_valid with waddr=0, wdata=0xFFFFFFFF → mem_ready=1; next cycle rf_wren=0; busy unchanged.
- issue_valid waddr=7 → busy[7]=1 next cycle; later ALU write to 7 accepted → busy[7]=0 in the cycle rf_wren=1.
- Same cycle: issue_valid waddr=9 and accepted write to 9 with busy[9]=1 → busy[9] stays 1; issue_valid waddr=0 → busy[0] stays 0.
- Assert rst asynchronously in the cycle after a handshake → rf_wren drops to 0 without waiting for clk; busy=0; after release, first contention grants ALU.

Source files
------------

// File: rtl/regfile_wb_arbiter_if.sv
// Write-back bus between the ALU/load producers, decode issue and the register file write port.
interface regfile_wb_arbiter_if #(
  parameter int NREG = 32,
  parameter int DW   = 32
);
  localparam int AW = $clog2(NREG);

  logic          alu_valid;
  logic          alu_ready;
  logic [AW-1:0] alu_waddr;
  logic [DW-1:0] alu_wdata;
  logic          mem_valid;
  logic          mem_ready;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;
  logic          issue_valid;
  logic [AW-1:0] issue_waddr;
  logic          rf_wren;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic [NREG-1:0] busy;

  modport master (
    output alu_valid, alu_waddr, alu_wdata,
    output mem_valid, mem_waddr, mem_wdata,
    output issue_valid, issue_waddr,
    input  alu_ready, mem_ready, rf_wren, rf_waddr, rf_wdata, busy
  );

  modport slave (
    input  alu_valid, alu_waddr, alu_wdata,
    input  mem_valid, mem_waddr, mem_wdata,
    input  issue_valid, issue_waddr,
    output alu_ready, mem_ready, rf_wren, rf_waddr, rf_wdata, busy
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter (ALU vs load) with pending-write scoreboard for the MIPS register file.
// Define REGFILE_WB_FIXED_PRIO_EN for fixed MEM-over-ALU priority instead of round-robin.
module regfile_wb_arbiter #(
  parameter int NREG = 32,
  parameter int DW   = 32
) (
  input logic              clk,
  input logic              rst,
  regfile_wb_arbiter_if.slave bus
);
  localparam int AW = $clog2(NREG);

  logic            alu_hs;
  logic            mem_hs;
  logic            any_hs;
  logic [AW-1:0]   win_addr;
  logic [DW-1:0]   win_data;
  logic            rf_wren_q;
  logic [AW-1:0]   rf_waddr_q;
  logic [DW-1:0]   rf_wdata_q;
  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_next;

`ifdef REGFILE_WB_FIXED_PRIO_EN
  assign bus.alu_ready = ~bus.mem_valid;
  assign bus.mem_ready = 1'b1;
`else
  typedef enum logic {GRANT_ALU = 1'b0, GRANT_MEM = 1'b1} grant_e;
  grant_e last_grant;

  assign bus.alu_ready = ~bus.mem_valid | (last_grant == GRANT_MEM);
  assign bus.mem_ready = ~bus.alu_valid | (last_grant == GRANT_ALU);

  // Only contended cycles move the pointer; a lone requester never steals the next turn.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= GRANT_MEM;
    end else if (bus.alu_valid && bus.mem_valid) begin
      last_grant <= alu_hs ? GRANT_ALU : GRANT_MEM;
    end
  end
`endif

  assign alu_hs = bus.alu_valid & bus.alu_ready;
  assign mem_hs = bus.mem_valid & bus.mem_ready;
  assign any_hs = alu_hs | mem_hs;

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    win_addr = bus.alu_waddr;
    win_data = bus.alu_wdata;
    if (mem_hs) begin
      win_addr = bus.mem_waddr;
      win_data = bus.mem_wdata;
    end
  end

  // Issue is applied after the clear so a same-cycle issue to the written register stays busy.
  always_comb begin
    busy_next = busy_q;
    if (any_hs) busy_next[win_addr] = 1'b0;
    if (bus.issue_valid) busy_next[bus.issue_waddr] = 1'b1;
    busy_next[0] = 1'b0;
  end

  // NOTE: the scoreboard is a handful of flops, not a RAM, so it is reset along with the rest.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_wren_q  <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      busy_q     <= '0;
    end else begin
      busy_q    <= busy_next;
      rf_wren_q <= any_hs && (win_addr != '0);
      if (any_hs) begin
        rf_waddr_q <= win_addr;
        rf_wdata_q <= win_data;
      end
    end
  end

  assign bus.rf_wren  = rf_wren_q;
  assign bus.rf_waddr = rf_waddr_q;
  assign bus.rf_wdata = rf_wdata_q;
  assign bus.busy     = busy_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter; honours REGFILE_WB_FIXED_PRIO_EN.
module tb_regfile_wb_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  regfile_wb_arbiter_if #(.NREG(32), .DW(32)) bus ();

  regfile_wb_arbiter #(.NREG(32), .DW(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

`ifdef REGFILE_WB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.alu_valid   = 1'b0;
    bus.mem_valid   = 1'b0;
    bus.issue_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] exp_addr;
    idle();
    bus.alu_waddr = '0;  bus.alu_wdata = '0;
    bus.mem_waddr = '0;  bus.mem_wdata = '0;
    bus.issue_waddr = '0;

    // Reset state
    tick();
    check("rst_wren",  32'(bus.rf_wren), 32'd0);
    check("rst_waddr", 32'(bus.rf_waddr), 32'd0);
    check("rst_wdata", bus.rf_wdata, 32'd0);
    check("rst_busy",  bus.busy, 32'd0);
    rst = 1'b0;
    tick();

    // Single ALU write
    bus.alu_valid = 1'b1; bus.alu_waddr = 5'd5; bus.alu_wdata = 32'h1234;
    #1 check("alu_ready_single", 32'(bus.alu_ready), 32'd1);
    tick();
    idle();
    check("single_wren",  32'(bus.rf_wren), 32'd1);
    check("single_waddr", 32'(bus.rf_waddr), 32'd5);
    check("single_wdata", bus.rf_wdata, 32'h0000_1234);
    tick();
    check("single_wren_drop", 32'(bus.rf_wren), 32'd0);
    check("single_waddr_hold", 32'(bus.rf_waddr), 32'd5);

    // Sustained contention
    bus.alu_valid = 1'b1; bus.alu_waddr = 5'd3; bus.alu_wdata = 32'hA3A3_A3A3;
    bus.mem_valid = 1'b1; bus.mem_waddr = 5'd4; bus.mem_wdata = 32'hB4B4_B4B4;
    for (int i = 0; i < 4; i++) begin
      exp_addr = FIXED ? 32'd4 : ((i % 2 == 0) ? 32'd3 : 32'd4);
      #1;
      check($sformatf("rr_alu_ready%0d", i), 32'(bus.alu_ready), 32'(exp_addr == 32'd3));
      check($sformatf("rr_mem_ready%0d", i), 32'(bus.mem_ready), 32'(exp_addr == 32'd4));
      tick();
      check($sformatf("rr_wren%0d", i),  32'(bus.rf_wren), 32'd1);
      check($sformatf("rr_waddr%0d", i), 32'(bus.rf_waddr), exp_addr);
      check($sformatf("rr_wdata%0d", i), bus.rf_wdata,
            (exp_addr == 32'd3) ? 32'hA3A3_A3A3 : 32'hB4B4_B4B4);
    end
    idle();

    // Load to $zero is accepted and dropped
    bus.mem_valid = 1'b1; bus.mem_waddr = 5'd0; bus.mem_wdata = 32'hFFFF_FFFF;
    #1 check("zero_mem_ready", 32'(bus.mem_ready), 32'd1);
    tick();
    idle();
    check("zero_wren", 32'(bus.rf_wren), 32'd0);
    check("zero_busy", bus.busy, 32'd0);

    // Issue sets busy, later write clears it in the rf_wren cycle
    bus.issue_valid = 1'b1; bus.issue_waddr = 5'd7;
    tick();
    idle();
    check("issue7_busy", bus.busy, 32'h0000_0080);
    bus.alu_valid = 1'b1; bus.alu_waddr = 5'd7; bus.alu_wdata = 32'h77;
    tick();
    idle();
    check("wb7_wren", 32'(bus.rf_wren), 32'd1);
    check("wb7_busy", bus.busy, 32'd0);

    // Same-cycle issue and write to 9: set wins
    bus.issue_valid = 1'b1; bus.issue_waddr = 5'd9;
    tick();
    check("issue9_busy", bus.busy, 32'h0000_0200);
    bus.alu_valid = 1'b1; bus.alu_waddr = 5'd9; bus.alu_wdata = 32'h99;
    tick();
    idle();
    check("same9_wren", 32'(bus.rf_wren), 32'd1);
    check("same9_busy", bus.busy, 32'h0000_0200);
    bus.issue_valid = 1'b1; bus.issue_waddr = 5'd0;
    tick();
    idle();
    check("issue0_busy", bus.busy, 32'h0000_0200);

    // Contended handshake (moves pointer to ALU), then async reset mid-cycle
    bus.alu_valid = 1'b1; bus.alu_waddr = 5'd2; bus.alu_wdata = 32'h22;
    bus.mem_valid = 1'b1; bus.mem_waddr = 5'd4; bus.mem_wdata = 32'h44;
    tick();
    idle();
    check("pre_rst_wren",  32'(bus.rf_wren), 32'd1);
    check("pre_rst_waddr", 32'(bus.rf_waddr), FIXED ? 32'd4 : 32'd2);
    #1 rst = 1'b1;
    #1;
    check("async_rst_wren", 32'(bus.rf_wren), 32'd0);
    check("async_rst_busy", bus.busy, 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // First contention after reset goes to ALU
    bus.alu_valid = 1'b1; bus.alu_waddr = 5'd3; bus.alu_wdata = 32'h33;
    bus.mem_valid = 1'b1; bus.mem_waddr = 5'd4; bus.mem_wdata = 32'h44;
    #1;
    check("post_rst_alu_ready", 32'(bus.alu_ready), FIXED ? 32'd0 : 32'd1);
    check("post_rst_mem_ready", 32'(bus.mem_ready), FIXED ? 32'd1 : 32'd0);
    tick();
    idle();
    check("post_rst_waddr", 32'(bus.rf_waddr), FIXED ? 32'd4 : 32'd3);
    check("post_rst_wren",  32'(bus.rf_wren), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
